// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Optional same-cycle write bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [XLEN_DEF-1:0] reg_data_t;
  typedef logic [AW_DEF-1:0]   reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits plus a running count of outstanding reservations.
// The count tracks busy-bit transitions, so it always equals the number of set bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      pending_cnt
);

  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] busy_nxt;
  logic             inc;
  logic             dec;

  for (genvar i = 0; i < NREGS; i++) begin : g_bit
    if (i == 0) begin : g_zero
      assign set_vec[i] = 1'b0;
      assign clr_vec[i] = 1'b0;
    end else begin : g_reg
      assign set_vec[i] = issue_en && (issue_rd == AW'(i));
      assign clr_vec[i] = wr_en && (wr_addr == AW'(i));
    end
  end

  // Set is applied after clear, so a same-cycle issue keeps the register reserved.
  assign busy_nxt = flush ? '0 : ((busy & ~clr_vec) | set_vec);

  // At most one issue and one write per cycle, so each direction moves by one.
  assign inc = |(set_vec & ~busy);
  assign dec = |(clr_vec & busy & ~set_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= flush ? '0 : (pending_cnt + (AW+1)'(inc) - (AW+1)'(dec));
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with a RAW/WAW issue scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ok,
  input  logic            flush,
  output logic [AW:0]     pending_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             hit1;
  logic             hit2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .flush       (flush),
    .busy        (busy),
    .pending_cnt (pending_cnt)
  );

`ifdef REGFILE_BYPASS_EN
  assign hit1 = wr_en && (wr_addr == rs1_addr) && (rs1_addr != '0);
  assign hit2 = wr_en && (wr_addr == rs2_addr) && (rs2_addr != '0);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // Reads are masked while rst is high so stale contents never leak out during reset.
  assign rs1_data = (rst || rs1_addr == '0) ? '0 : (hit1 ? wr_data : regs[rs1_addr]);
  assign rs2_data = (rst || rs2_addr == '0) ? '0 : (hit2 ? wr_data : regs[rs2_addr]);
  assign rs1_busy = !rst && !hit1 && (rs1_addr != '0) && busy[rs1_addr];
  assign rs2_busy = !rst && !hit2 && (rs2_addr != '0) && busy[rs2_addr];

  assign issue_ok = !(rs1_busy || rs2_busy || (!rst && busy[issue_rd]));

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and random checks of regfile_sb against an array-based reference model.
// Honours REGFILE_BYPASS_EN to match the build of the design under test.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, issue_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, wr_data;
  logic            rs1_busy, rs2_busy, wr_en, issue_en, issue_ok, flush;
  logic [AW:0]     pending_cnt;

  int checks = 0;
  int errors = 0;
  bit cnt_valid = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_ok(issue_ok),
    .flush(flush), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit bypass_hit(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return wr_en && (wr_addr == a) && (a != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (rst || a == 0) return '0;
    if (bypass_hit(a)) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    if (rst || a == 0 || bypass_hit(a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_outputs();
    bit ok;
    ok = !(exp_busy(rs1_addr) || exp_busy(rs2_addr) || (!rst && m_busy[issue_rd]));
    chk("rs1_data", rs1_data, exp_data(rs1_addr));
    chk("rs2_data", rs2_data, exp_data(rs2_addr));
    chk("rs1_busy", rs1_busy, exp_busy(rs1_addr));
    chk("rs2_busy", rs2_busy, exp_busy(rs2_addr));
    chk("issue_ok", issue_ok, ok);
    if (cnt_valid) chk("pending_cnt", pending_cnt, 64'(m_pending()));
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
      end else begin
        if (wr_en && wr_addr != 0) m_busy[wr_addr] = 1'b0;
        if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    cnt_valid = 1;
    @(negedge clk);
  endtask

  task automatic set_in(input bit r, input bit we, input logic [AW-1:0] wa,
                        input logic [XLEN-1:0] wd, input bit ie, input logic [AW-1:0] rd,
                        input bit fl, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_rd = rd; flush = fl; rs1_addr = a1; rs2_addr = a2;
  endtask

  initial begin
    logic [XLEN-1:0] kept [5];
    kept[0] = 0; kept[1] = 5; kept[2] = 6; kept[3] = 'hA; kept[4] = 'h44;

    // Reset
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 2);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 2);
    #1;
    chk("rst_rs1_data", rs1_data, 0);
    chk("rst_pending", pending_cnt, 0);
    chk("rst_issue_ok", issue_ok, 1);
    tick();

    // Basic write then read
    set_in(0, 1, 1, 5, 0, 0, 0, 0, 0); tick();
    set_in(0, 1, 2, 6, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 2);
    #1;
    chk("rd_x1", rs1_data, 5);
    chk("rd_x2", rs2_data, 6);
    chk("rd_ok", issue_ok, 1);
    tick();

    // Register 0 is hardwired
    set_in(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("x0_data", rs1_data, 0);
    chk("x0_busy", rs1_busy, 0);
    chk("x0_pending", pending_cnt, 0);
    tick();

    // Reservation and release
    set_in(0, 0, 0, 0, 1, 3, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 3, 0);
    #1;
    chk("x3_busy", rs1_busy, 1);
    chk("x3_ok", issue_ok, 0);
    chk("x3_pending", pending_cnt, 1);
    tick();
    set_in(0, 1, 3, 'hA, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 3, 0);
    #1;
    chk("x3_clr_busy", rs1_busy, 0);
    chk("x3_clr_pending", pending_cnt, 0);
    chk("x3_data", rs1_data, 'hA);
    tick();

    // Re-reserving x4 while its old write lands keeps it busy and the count steady
    set_in(0, 0, 0, 0, 1, 4, 0, 0, 0); tick();
    set_in(0, 1, 4, 'h44, 1, 4, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 4, 0);
    #1;
    chk("x4_busy", rs1_busy, 1);
    chk("x4_pending", pending_cnt, 1);
    tick();
    set_in(0, 1, 5, 'h1E, 0, 0, 0, 0, 5);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x5_bypass", rs2_data, 'h1E);
`else
    chk("x5_nobypass", rs2_data, 0);
`endif
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 5);
    #1;
    chk("x5_data", rs2_data, 'h1E);
    tick();

    // Fill and flush
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    for (int r = 1; r <= 7; r++) begin
      set_in(0, 0, 0, 0, 1, AW'(r), 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("fill_pending", pending_cnt, 7);
    tick();
    for (int r = 1; r <= 7; r++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, AW'(r), 0);
      #1;
      chk("flush_busy", rs1_busy, 0);
      chk("flush_pending", pending_cnt, 0);
      if (r <= 4) chk("flush_kept", rs1_data, kept[r]);
      tick();
    end

    // Reset in the middle of activity
    for (int r = 5; r <= 7; r++) begin
      set_in(0, 0, 0, 0, 1, AW'(r), 0, 0, 0);
      tick();
    end
    set_in(1, 1, 9, 'h99, 1, 8, 0, 0, 0);
    #1;
    chk("mid_pending", pending_cnt, 3);
    tick();
    for (int r = 0; r < NREGS; r++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, AW'(r), AW'(NREGS - 1 - r));
      #1;
      chk("mid_rst_data", rs1_data, 0);
      chk("mid_rst_busy", rs1_busy, 0);
      chk("mid_rst_pending", pending_cnt, 0);
      tick();
    end

    // Random traffic; writes lean towards reserved registers
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, NREGS - 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < NREGS; k++) begin
          if (m_busy[(int'(wa) + k) % NREGS]) begin
            wa = AW'((int'(wa) + k) % NREGS);
            break;
          end
        end
      end
      set_in($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, wa, $urandom(),
             $urandom_range(0, 2) != 0, AW'($urandom_range(0, NREGS - 1)),
             $urandom_range(0, 24) == 0,
             AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)));
      if ($urandom_range(0, 3) == 0) rs1_addr = wa;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
